// File: rtl/sd_wrrmux.sv
// sd_wrrmux: weighted round-robin mux for srdy/drdy streams with a registered output stage.
// Define SD_WRR_STARVE_EN to add per-input wait counters that cut a quantum short on starvation.
module sd_wrrmux #(
    parameter int width      = 8,
    parameter int inputs     = 4,
    parameter int wt_sz      = 4,
    parameter int starve_lim = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [inputs-1:0]       c_srdy,
    output logic [inputs-1:0]       c_drdy,
    input  logic [width*inputs-1:0] c_data,
    input  logic [wt_sz*inputs-1:0] cfg_weight,
    output logic                    p_srdy,
    input  logic                    p_drdy,
    output logic [width-1:0]        p_data,
    output logic [inputs-1:0]       p_grant
);
    localparam int IW = $clog2(inputs);

    if (inputs < 2 || inputs > 16 || starve_lim < 1) begin : g_paramCheck
        $error("sd_wrrmux: unsupported parameter value");
    end

    logic [IW-1:0]     r_cur;
    logic [wt_sz-1:0]  r_cnt;
    logic              r_hold;

    logic [wt_sz-1:0]  w_weight [inputs];
    logic [width-1:0]  w_data   [inputs];
    logic [inputs-1:0] w_eligible;
    logic [IW-1:0]     w_rrNext;
    logic [IW-1:0]     w_sel;
    logic              w_rrFound;
    logic              w_selValid;
    logic              w_newQuantum;
    logic              w_canLoad;
    logic              w_xfer;

    function automatic logic [IW-1:0] wrapAdd(input logic [IW-1:0] base, input int offset);
        int sum;
        sum = int'(base) + offset;
        if (sum >= inputs) sum = sum - inputs;
        return sum[IW-1:0];
    endfunction

    always_comb begin
        for (int i = 0; i < inputs; i++) begin
            w_weight[i]   = cfg_weight[wt_sz*i +: wt_sz];
            w_data[i]     = c_data[width*i +: width];
            w_eligible[i] = c_srdy[i] && (cfg_weight[wt_sz*i +: wt_sz] != '0);
        end
    end

    // Round-robin search starts just past the current owner, so cur=inputs-1 makes input 0 win first.
    always_comb begin
        w_rrNext  = r_cur;
        w_rrFound = 1'b0;
        for (int k = 1; k <= inputs; k++) begin
            if (!w_rrFound && w_eligible[wrapAdd(r_cur, k)]) begin
                w_rrNext  = wrapAdd(r_cur, k);
                w_rrFound = 1'b1;
            end
        end
    end

`ifdef SD_WRR_STARVE_EN
    localparam int WW = $clog2(starve_lim + 1);

    logic [WW-1:0]     r_wait [inputs];
    logic [inputs-1:0] w_starved;
    logic              w_starveAny;
    logic [IW-1:0]     w_starveIdx;

    always_comb begin
        w_starveAny = 1'b0;
        w_starveIdx = '0;
        for (int i = 0; i < inputs; i++) begin
            w_starved[i] = w_eligible[i] && (r_wait[i] == WW'(starve_lim));
        end
        for (int i = inputs - 1; i >= 0; i--) begin
            if (w_starved[i]) begin
                w_starveAny = 1'b1;
                w_starveIdx = IW'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < inputs; i++) r_wait[i] <= '0;
        end else begin
            for (int i = 0; i < inputs; i++) begin
                if (!w_eligible[i] || c_drdy[i]) begin
                    r_wait[i] <= '0;
                end else if (r_wait[i] != WW'(starve_lim)) begin
                    r_wait[i] <= r_wait[i] + WW'(1);
                end
            end
        end
    end
`endif

    // A held owner keeps the channel even if its weight was zeroed; a starved input overrides both.
    always_comb begin
        if (r_hold && c_srdy[r_cur]) begin
            w_sel        = r_cur;
            w_newQuantum = 1'b0;
            w_selValid   = 1'b1;
        end else begin
            w_sel        = w_rrNext;
            w_newQuantum = 1'b1;
            w_selValid   = w_rrFound;
        end
`ifdef SD_WRR_STARVE_EN
        if (w_starveAny) begin
            w_sel        = w_starveIdx;
            w_newQuantum = 1'b1;
            w_selValid   = 1'b1;
        end
`endif
    end

    assign w_canLoad = !p_srdy || p_drdy;
    assign w_xfer    = w_selValid && w_canLoad && reset;

    always_comb begin
        c_drdy = '0;
        if (w_xfer) c_drdy[w_sel] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            p_srdy  <= 1'b0;
            p_data  <= '0;
            p_grant <= '0;
            r_cur   <= IW'(inputs - 1);
            r_cnt   <= '0;
            r_hold  <= 1'b0;
        end else if (w_xfer) begin
            p_srdy  <= 1'b1;
            p_data  <= w_data[w_sel];
            p_grant <= c_drdy;
            if (w_newQuantum) begin
                r_cur  <= w_sel;
                r_cnt  <= w_weight[w_sel] - wt_sz'(1);
                r_hold <= (w_weight[w_sel] > wt_sz'(1));
            end else begin
                r_cnt  <= r_cnt - wt_sz'(1);
                r_hold <= (r_cnt > wt_sz'(1));
            end
        end else begin
            if (p_drdy) p_srdy <= 1'b0;
            // An owner that went idle forfeits the rest of its quantum; a stalled output freezes it.
            if (w_canLoad && r_hold && !c_srdy[r_cur]) r_hold <= 1'b0;
        end
    end
endmodule
